// File: rtl/pintor_objetivo_pkg.sv
// Shared definitions for the target painter: FSM encoding, grid geometry,
// LFSR taps and the helper that keeps the sprite origin on the grid.
package pkg_juego;

  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    PINTA   = 2'd1,
    VISIBLE = 2'd2,
    BORRA   = 2'd3
  } estado_t;

  localparam int GRID_W = 4;
  localparam int SPRITE = 2;

  // Feedback taps: lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  // Largest origin that still fits the full sprite on the grid
  localparam logic [GRID_W-1:0] MAX_ORIGEN = GRID_W'((2 ** GRID_W) - SPRITE);

  function automatic logic retroLfsr(input logic [7:0] valor);
    return ^(valor & LFSR_TAPS);
  endfunction

  function automatic logic [GRID_W-1:0] limitar(input logic [GRID_W-1:0] c);
    return (c > MAX_ORIGEN) ? MAX_ORIGEN : c;
  endfunction

endpackage

// File: rtl/pintor_objetivo_lfsr8.sv
// 8-bit Fibonacci LFSR with synchronous seed load and step enable.
module lfsr8
  import pkg_juego::*;
#(
  parameter logic [7:0] SEMILLA = 8'h01
) (
  input  logic       iClk,
  input  logic       iReset,
  input  logic       iEnable,
  output logic [7:0] oValor
);

  always_ff @(posedge iClk) begin
    if (iReset) begin
      oValor <= SEMILLA;
    end else if (iEnable) begin
      oValor <= {oValor[6:0], retroLfsr(oValor)};
    end
  end

endmodule

// File: rtl/pintor_objetivo.sv
// Latches a random target cell and paints/erases a 2x2 sprite into the frame
// buffer, one pixel per cycle. oEstado and oLfsr are debug views.
module pintor_objetivo
  import pkg_juego::*;
#(
  parameter int                 COLOR_W   = 3,
  parameter logic [COLOR_W-1:0] COLOR_OBJ = 3'b100,
  parameter logic [7:0]         SEMILLA   = 8'h01
) (
  input  logic               iClk,
  input  logic               iReset,
  input  logic               iEnableLFSR,
  input  logic               iPintar,
  input  logic               iResetPintar,
  output logic               oWe,
  output logic [7:0]         oAddr,
  output logic [COLOR_W-1:0] oDato,
  output logic [3:0]         oPosX,
  output logic [3:0]         oPosY,
  output logic               oVisible,
  output logic               oBusy,
  output estado_t            oEstado,
  output logic [7:0]         oLfsr
);

  // Strobes are single-cycle pulses sampled on the rising edge; they carry
  // no ready handshake, so a strobe the current state ignores is dropped.

  estado_t      estado, estadoSig;
  logic [1:0]   k, kSig;
  logic [3:0]   posXSig, posYSig;
  logic         pendiente, pendienteSig;
  logic         weSig, visibleSig;
  logic [7:0]   addrSig;
  logic [COLOR_W-1:0] datoSig;
  logic [7:0]   lfsr;

  lfsr8 #(.SEMILLA(SEMILLA)) uLfsr (
    .iClk    (iClk),
    .iReset  (iReset),
    .iEnable (iEnableLFSR),
    .oValor  (lfsr)
  );

  always_ff @(posedge iClk) begin
    if (iReset) begin
      estado    <= REPOSO;
      k         <= 2'd0;
      pendiente <= 1'b0;
      oPosX     <= 4'd0;
      oPosY     <= 4'd0;
      oWe       <= 1'b0;
      oAddr     <= 8'd0;
      oDato     <= '0;
      oVisible  <= 1'b0;
      oBusy     <= 1'b0;
    end else begin
      estado    <= estadoSig;
      k         <= kSig;
      pendiente <= pendienteSig;
      oPosX     <= posXSig;
      oPosY     <= posYSig;
      oWe       <= weSig;
      oAddr     <= addrSig;
      oDato     <= datoSig;
      oVisible  <= visibleSig;
      oBusy     <= weSig;
    end
  end

  // Outputs are derived from the next-state values so they line up with the
  // state they describe once registered.
  always_comb begin
    estadoSig    = estado;
    kSig         = k;
    posXSig      = oPosX;
    posYSig      = oPosY;
    pendienteSig = pendiente;

    case (estado)
      REPOSO: begin
        if (iPintar) begin
          estadoSig    = PINTA;
          kSig         = 2'd0;
          posXSig      = limitar(lfsr[3:0]);
          posYSig      = limitar(lfsr[7:4]);
          pendienteSig = iResetPintar;
        end
      end
      PINTA: begin
        if (iResetPintar) pendienteSig = 1'b1;
        if (k == 2'd3) begin
          estadoSig = pendienteSig ? BORRA : VISIBLE;
          kSig      = 2'd0;
        end else begin
          kSig = k + 2'd1;
        end
      end
      VISIBLE: begin
        if (iResetPintar) begin
          estadoSig = BORRA;
          kSig      = 2'd0;
        end
      end
      BORRA: begin
        pendienteSig = 1'b0;
        if (k == 2'd3) begin
          estadoSig = REPOSO;
          kSig      = 2'd0;
        end else begin
          kSig = k + 2'd1;
        end
      end
      default: estadoSig = REPOSO;
    endcase

    weSig      = (estadoSig == PINTA) || (estadoSig == BORRA);
    visibleSig = (estadoSig == VISIBLE);
    datoSig    = (estadoSig == PINTA) ? COLOR_OBJ : '0;
    addrSig    = weSig ? {posYSig + 4'(kSig[1]), posXSig + 4'(kSig[0])} : 8'd0;
  end

  assign oEstado = estado;
  assign oLfsr   = lfsr;

endmodule

// File: tb/tb_pintor_objetivo.sv
// Directed bench for pintor_objetivo: seed 0x01 instance for the main flow,
// seed 0xFF instance for coordinate clamping.
module tb_pintor_objetivo;
  import pkg_juego::*;

  logic       iClk;
  logic       iReset, iEnableLFSR, iPintar, iResetPintar;
  logic       oWe, oVisible, oBusy;
  logic [7:0] oAddr, oLfsr;
  logic [2:0] oDato;
  logic [3:0] oPosX, oPosY;
  estado_t    oEstado;

  logic       iReset2, iPintar2;
  logic       oWe2, oVisible2, oBusy2;
  logic [7:0] oAddr2, oLfsr2;
  logic [2:0] oDato2;
  logic [3:0] oPosX2, oPosY2;
  estado_t    oEstado2;

  int nChecks;
  int nFails;

  logic [7:0] addrA [4];
  logic [7:0] addrB [4];
  logic [7:0] addrC [4];
  logic [7:0] lfsrEsp [4];

  pintor_objetivo #(.COLOR_W(3), .COLOR_OBJ(3'b100), .SEMILLA(8'h01)) dut (
    .iClk(iClk), .iReset(iReset), .iEnableLFSR(iEnableLFSR), .iPintar(iPintar),
    .iResetPintar(iResetPintar), .oWe(oWe), .oAddr(oAddr), .oDato(oDato),
    .oPosX(oPosX), .oPosY(oPosY), .oVisible(oVisible), .oBusy(oBusy),
    .oEstado(oEstado), .oLfsr(oLfsr)
  );

  pintor_objetivo #(.COLOR_W(3), .COLOR_OBJ(3'b100), .SEMILLA(8'hFF)) dutFF (
    .iClk(iClk), .iReset(iReset2), .iEnableLFSR(1'b0), .iPintar(iPintar2),
    .iResetPintar(1'b0), .oWe(oWe2), .oAddr(oAddr2), .oDato(oDato2),
    .oPosX(oPosX2), .oPosY(oPosY2), .oVisible(oVisible2), .oBusy(oBusy2),
    .oEstado(oEstado2), .oLfsr(oLfsr2)
  );

  // Clock and reset
  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    nChecks++;
    assert (obs === esp) else begin
      nFails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, esp);
    end
  endtask

  task automatic chkWrite(input string tag, input logic [7:0] addr, input logic [2:0] dato);
    chk({tag, "_we"}, 32'(oWe), 32'd1);
    chk({tag, "_busy"}, 32'(oBusy), 32'd1);
    chk({tag, "_addr"}, 32'(oAddr), 32'(addr));
    chk({tag, "_dato"}, 32'(oDato), 32'(dato));
    chk({tag, "_visible"}, 32'(oVisible), 32'd0);
  endtask

  initial begin
    nChecks = 0;
    nFails  = 0;
    addrA = '{8'h11, 8'h12, 8'h21, 8'h22};
    addrB = '{8'hEE, 8'hEF, 8'hFE, 8'hFF};
    addrC = '{8'h01, 8'h02, 8'h11, 8'h12};
    lfsrEsp = '{8'h02, 8'h04, 8'h08, 8'h11};
    iReset = 1'b1; iEnableLFSR = 1'b0; iPintar = 1'b0; iResetPintar = 1'b0;
    iReset2 = 1'b1; iPintar2 = 1'b0;
    tick(); tick();
    iReset = 1'b0;
    tick();

    // Reset state
    chk("rst_we", 32'(oWe), 32'd0);
    chk("rst_addr", 32'(oAddr), 32'd0);
    chk("rst_dato", 32'(oDato), 32'd0);
    chk("rst_posx", 32'(oPosX), 32'd0);
    chk("rst_posy", 32'(oPosY), 32'd0);
    chk("rst_visible", 32'(oVisible), 32'd0);
    chk("rst_busy", 32'(oBusy), 32'd0);
    chk("rst_lfsr", 32'(oLfsr), 32'h01);
    chk("rst_estado", 32'(oEstado), 32'(REPOSO));

    // LFSR stepping
    iEnableLFSR = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("lfsr_step%0d", i), 32'(oLfsr), 32'(lfsrEsp[i]));
    end
    iEnableLFSR = 1'b0;

    // Paint at (1,1)
    iPintar = 1'b1;
    tick();
    iPintar = 1'b0;
    chk("paint_posx", 32'(oPosX), 32'd1);
    chk("paint_posy", 32'(oPosY), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chkWrite($sformatf("paint_w%0d", i), addrA[i], 3'b100);
      tick();
    end
    chk("paint_done_we", 32'(oWe), 32'd0);
    chk("paint_done_visible", 32'(oVisible), 32'd1);
    chk("paint_done_busy", 32'(oBusy), 32'd0);

    // Erase it
    iResetPintar = 1'b1;
    tick();
    iResetPintar = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chkWrite($sformatf("erase_w%0d", i), addrA[i], 3'b000);
      tick();
    end
    chk("erase_done_we", 32'(oWe), 32'd0);
    chk("erase_done_busy", 32'(oBusy), 32'd0);
    chk("erase_done_estado", 32'(oEstado), 32'(REPOSO));

    // Erase request on 2nd paint cycle: 8 back-to-back writes
    iPintar = 1'b1;
    tick();
    iPintar = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 1) iResetPintar = 1'b1;
      if (i == 2) iResetPintar = 1'b0;
      chkWrite($sformatf("pend_w%0d", i), addrA[i % 4], (i < 4) ? 3'b100 : 3'b000);
      tick();
    end
    chk("pend_done_busy", 32'(oBusy), 32'd0);
    chk("pend_done_visible", 32'(oVisible), 32'd0);
    chk("pend_done_estado", 32'(oEstado), 32'(REPOSO));

    // Paint, then move LFSR to 0x23 and retry iPintar while VISIBLE
    iPintar = 1'b1;
    tick();
    iPintar = 1'b0;
    tick(); tick(); tick(); tick();
    chk("vis_visible", 32'(oVisible), 32'd1);
    iEnableLFSR = 1'b1;
    tick();
    iEnableLFSR = 1'b0;
    chk("vis_lfsr", 32'(oLfsr), 32'h23);
    iPintar = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("vis_ign%0d_we", i), 32'(oWe), 32'd0);
      chk($sformatf("vis_ign%0d_posx", i), 32'(oPosX), 32'd1);
      chk($sformatf("vis_ign%0d_posy", i), 32'(oPosY), 32'd1);
      chk($sformatf("vis_ign%0d_visible", i), 32'(oVisible), 32'd1);
    end
    iPintar = 1'b0;

    // Erase back to idle, then reset during the 3rd paint cycle
    iResetPintar = 1'b1;
    tick();
    iResetPintar = 1'b0;
    tick(); tick(); tick(); tick();
    chk("pre_abort_estado", 32'(oEstado), 32'(REPOSO));
    iPintar = 1'b1;
    tick();
    iPintar = 1'b0;
    chk("abort_posx", 32'(oPosX), 32'd3);
    chk("abort_posy", 32'(oPosY), 32'd2);
    tick(); tick();
    chkWrite("abort_w2", 8'h33, 3'b100);
    iReset = 1'b1;
    tick();
    iReset = 1'b0;
    chk("abort_we", 32'(oWe), 32'd0);
    chk("abort_busy", 32'(oBusy), 32'd0);
    chk("abort_lfsr", 32'(oLfsr), 32'h01);
    chk("abort_estado", 32'(oEstado), 32'(REPOSO));

    // iPintar and iResetPintar together in idle: paint at (1,0) then erase
    iPintar = 1'b1;
    iResetPintar = 1'b1;
    tick();
    iPintar = 1'b0;
    iResetPintar = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chkWrite($sformatf("both_w%0d", i), addrC[i % 4], (i < 4) ? 3'b100 : 3'b000);
      tick();
    end
    chk("both_done_busy", 32'(oBusy), 32'd0);
    chk("both_done_estado", 32'(oEstado), 32'(REPOSO));

    // Seed 0xFF: both coordinates clamp to 14
    iReset2 = 1'b0;
    tick();
    iPintar2 = 1'b1;
    tick();
    iPintar2 = 1'b0;
    chk("clamp_posx", 32'(oPosX2), 32'd14);
    chk("clamp_posy", 32'(oPosY2), 32'd14);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("clamp_w%0d_we", i), 32'(oWe2), 32'd1);
      chk($sformatf("clamp_w%0d_addr", i), 32'(oAddr2), 32'(addrB[i]));
      chk($sformatf("clamp_w%0d_dato", i), 32'(oDato2), 32'(3'b100));
      tick();
    end
    chk("clamp_done_visible", 32'(oVisible2), 32'd1);
    chk("clamp_done_busy", 32'(oBusy2), 32'd0);
    chk("clamp_lfsr", 32'(oLfsr2), 32'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
    $finish;
  end

endmodule
